// File: rtl/stim_pkg.sv
// Shared types for the stimulus pattern generator.
// FSM state encoding and cfg_sel target encodings.
package stim_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    SEL_HP0   = 2'd0,
    SEL_HP1   = 2'd1,
    SEL_BURST = 2'd2,
    SEL_RSVD  = 2'd3
  } cfg_sel_t;

endpackage

// File: rtl/stim_pattern_gen_sq_div.sv
// sq_div: half-period counter, compare and toggle flop.
// Ports: clk, rst_n (sync), clr (sync), hp (half-period), q (square wave), hit (toggle this edge).
module sq_div #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [CNT_W-1:0] hp,
  output logic             q,
  output logic             hit
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt;

  // hp is never 0, so hp-1 never underflows and
  // cnt is cleared before it can wrap.
  assign hit = (cnt == (hp - ONE));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      cnt <= '0;
      q   <= 1'b0;
    end else if (hit) begin
      cnt <= '0;
      q   <= ~q;
    end else begin
      cnt <= cnt + ONE;
    end
  end

endmodule

// File: rtl/stim_pattern_gen.sv
// Two-tone square-wave stimulus generator with optional burst length.
// Ports: clk, rst_n, start, stop, cfg_we/sel/data in; drv0, drv1, edge0, busy, done out.
module stim_pattern_gen
  import stim_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int HP0_DEF = 200,
  parameter int HP1_DEF = 400
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  output logic             drv0,
  output logic             drv1,
  output logic             edge0,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  state_t           nxt;
  logic             done_n;
  logic             keep;
  logic             hit0;
  logic             hit1;
  logic [CNT_W-1:0] hp0;
  logic [CNT_W-1:0] hp1;
  logic [CNT_W-1:0] blen;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] wval;

  always_comb begin
    nxt    = state;
    done_n = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !stop) nxt = RUN;
      end
      RUN: begin
        if (stop) begin
          nxt = IDLE;
        end else if (blen != '0 && pcnt == blen) begin
          nxt    = IDLE;
          done_n = 1'b1;
        end
      end
    endcase
  end

  // Dividers run only while staying in RUN; the
  // accept edge and every exit edge clear them.
  assign keep = (state == RUN) && (nxt == RUN);
  assign busy = (state == RUN);
  assign wval = (cfg_data == '0) ? ONE : cfg_data;

  sq_div #(.CNT_W(CNT_W)) u_div0 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!keep),
    .hp    (hp0),
    .q     (drv0),
    .hit   (hit0)
  );

  sq_div #(.CNT_W(CNT_W)) u_div1 (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!keep),
    .hp    (hp1),
    .q     (drv1),
    .hit   (hit1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      edge0 <= 1'b0;
      done  <= 1'b0;
      pcnt  <= '0;
      hp0   <= CNT_W'(HP0_DEF);
      hp1   <= CNT_W'(HP1_DEF);
      blen  <= '0;
    end else begin
      state <= nxt;
      edge0 <= keep && hit0;
      done  <= done_n;
      if (!keep) begin
        pcnt <= '0;
      end else if (hit1 && drv1) begin
        pcnt <= pcnt + ONE;
      end
      if (state == IDLE && cfg_we) begin
        unique case (cfg_sel_t'(cfg_sel))
          SEL_HP0:   hp0  <= wval;
          SEL_HP1:   hp1  <= wval;
          SEL_BURST: blen <= cfg_data;
          SEL_RSVD:  ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_stim_pattern_gen.sv
// Self-checking bench for stim_pattern_gen.
// Vector table plus directed multi-cycle sequences.
module tb_stim_pattern_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        cfg_we;
  logic [1:0]  cfg_sel;
  logic [15:0] cfg_data;
  logic        drv0;
  logic        drv1;
  logic        edge0;
  logic        busy;
  logic        done;

  int ncmp = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  stim_pattern_gen dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .cfg_we   (cfg_we),
    .cfg_sel  (cfg_sel),
    .cfg_data (cfg_data),
    .drv0     (drv0),
    .drv1     (drv1),
    .edge0    (edge0),
    .busy     (busy),
    .done     (done)
  );

  typedef struct {
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] data;
    logic        d0;
    logic        d1;
    logic        e0;
    logic        b;
    logic        dn;
  } vec_t;

  vec_t tv[16];

  function automatic vec_t mkv(
    logic r, logic s, logic p, logic w,
    logic [1:0] sl, logic [15:0] dt,
    logic d0, logic d1, logic e0, logic b, logic dn
  );
    vec_t v;
    v.rst_n = r; v.start = s; v.stop = p;
    v.we = w; v.sel = sl; v.data = dt;
    v.d0 = d0; v.d1 = d1; v.e0 = e0;
    v.b = b; v.dn = dn;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic act, logic exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic chk_out(string tag, logic d0, logic d1,
                         logic e0, logic b, logic dn);
    chk({tag, ".drv0"}, drv0, d0);
    chk({tag, ".drv1"}, drv1, d1);
    chk({tag, ".edge0"}, edge0, e0);
    chk({tag, ".busy"}, busy, b);
    chk({tag, ".done"}, done, dn);
  endtask

  task automatic cfg(logic [1:0] sl, logic [15:0] dt);
    cfg_we = 1'b1; cfg_sel = sl; cfg_data = dt;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic do_start(string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_out({tag, ".accept"}, 0, 0, 0, 1, 0);
  endtask

  // Expected waveform k cycles after the accept edge.
  task automatic run_check(string tag, int h0, int h1,
                           int bl, int n);
    int dk;
    dk = 2 * h1 * bl + 1;
    for (int k = 1; k <= n; k++) begin
      tick();
      if (bl != 0 && k >= dk) begin
        chk_out($sformatf("%s.k%0d", tag, k), 0, 0, 0, 0,
                (k == dk) ? 1'b1 : 1'b0);
      end else begin
        chk_out($sformatf("%s.k%0d", tag, k),
                logic'((k / h0) % 2), logic'((k / h1) % 2),
                logic'(k % h0 == 0), 1, 0);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_we = 1'b0; cfg_sel = 2'd0; cfg_data = '0;

    tv[0]  = mkv(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tv[1]  = mkv(1, 0, 0, 1, 0, 0,  0, 0, 0, 0, 0);
    tv[2]  = mkv(1, 0, 0, 1, 1, 2,  0, 0, 0, 0, 0);
    tv[3]  = mkv(1, 0, 0, 1, 2, 1,  0, 0, 0, 0, 0);
    tv[4]  = mkv(1, 0, 0, 1, 3, 5,  0, 0, 0, 0, 0);
    tv[5]  = mkv(1, 1, 1, 0, 0, 0,  0, 0, 0, 0, 0);
    tv[6]  = mkv(1, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    tv[7]  = mkv(1, 0, 0, 1, 0, 9,  1, 0, 1, 1, 0);
    tv[8]  = mkv(1, 0, 0, 0, 0, 0,  0, 1, 1, 1, 0);
    tv[9]  = mkv(1, 1, 0, 0, 0, 0,  1, 1, 1, 1, 0);
    tv[10] = mkv(1, 0, 0, 0, 0, 0,  0, 0, 1, 1, 0);
    tv[11] = mkv(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1);
    tv[12] = mkv(1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    tv[13] = mkv(1, 1, 0, 0, 0, 0,  0, 0, 0, 1, 0);
    tv[14] = mkv(1, 0, 0, 0, 0, 0,  1, 0, 1, 1, 0);
    tv[15] = mkv(1, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0);

    tick();
    for (int i = 0; i < 16; i++) begin
      rst_n = tv[i].rst_n; start = tv[i].start;
      stop = tv[i].stop; cfg_we = tv[i].we;
      cfg_sel = tv[i].sel; cfg_data = tv[i].data;
      tick();
      chk_out($sformatf("tv%0d", i), tv[i].d0, tv[i].d1,
              tv[i].e0, tv[i].b, tv[i].dn);
    end
    start = 1'b0; stop = 1'b0; cfg_we = 1'b0;

    // Defaults after reset: 200 / 400 half-periods.
    rst_n = 1'b0;
    tick();
    chk_out("rst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    do_start("def");
    run_check("def", 200, 400, 0, 401);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_out("def.stop", 0, 0, 0, 0, 0);

    // Burst of two slow periods.
    cfg(2'd0, 16'd3);
    cfg(2'd1, 16'd6);
    cfg(2'd2, 16'd2);
    do_start("burst");
    run_check("burst", 3, 6, 2, 27);

    // Continuous run, stop at cycle 10.
    cfg(2'd2, 16'd0);
    do_start("cont");
    run_check("cont", 3, 6, 0, 9);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_out("cont.stop", 0, 0, 0, 0, 0);
    tick();
    chk_out("cont.after", 0, 0, 0, 0, 0);

    // hp0 written as 0 behaves as 1, then reset mid-run.
    cfg(2'd0, 16'd0);
    do_start("hp1");
    run_check("hp1", 1, 6, 0, 8);
    rst_n = 1'b0;
    tick();
    chk_out("midrst", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    tick();
    chk_out("postrst", 0, 0, 0, 0, 0);
    do_start("redef");
    run_check("redef", 200, 400, 0, 201);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nbad);
    $finish;
  end

endmodule

// File: doc/stim_pattern_gen.md
STIM_PATTERN_GEN -- requirements
Module: stim_pattern_gen

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of half-period and burst counters.
REQ-002 SHALL have parameter HP0_DEF, default 200, reset half-period of drv0 in clocks.
REQ-003 SHALL have parameter HP1_DEF, default 400, reset half-period of drv1 in clocks.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port start  input  1  request to begin a pattern run.
REQ-007 SHALL have port stop  input  1  request to abort a run.
REQ-008 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-009 SHALL have port cfg_sel  input  2  target: 0=hp0, 1=hp1, 2=burst_len, 3=reserved.
REQ-010 SHALL have port cfg_data  input  CNT_W  configuration value.
REQ-011 SHALL have port drv0  output  1  fast square wave, feeds the amplifier input node.
REQ-012 SHALL have port drv1  output  1  slow square wave, feeds the gate/bias node.
REQ-013 SHALL have port edge0  output  1  one-cycle strobe on each drv0 toggle, for downstream capture.
REQ-014 SHALL have port busy  output  1  high while running.
REQ-015 SHALL have port done  output  1  one-cycle pulse at natural burst completion.

Function
REQ-016 SHALL implement FSM states IDLE and RUN only; busy = (state==RUN).
REQ-017 SHALL accept cfg_we only in IDLE; writes in RUN and writes with cfg_sel=3 ignored.
REQ-018 SHALL store a written hp0/hp1 value of 0 as 1.
REQ-019 SHALL treat burst_len=0 as continuous run (no done); reset value of burst_len 0.
REQ-020 SHALL transition IDLE->RUN on start=1 with stop=0; counters cleared, drv0=drv1=0 in that cycle.
REQ-021 SHALL, in IDLE, give stop priority over simultaneous start (remain IDLE).
REQ-022 SHALL, in RUN, increment cnt0 each cycle; at cnt0==hp0-1, toggle drv0, assert edge0, clear cnt0.
REQ-023 SHALL handle drv1 identically with cnt1/hp1; hp=1 toggles every cycle.
REQ-024 SHALL make the first drv0 toggle exactly hp0 cycles after the start-accept edge.
REQ-025 SHALL count drv1 falling edges (full periods); when count reaches burst_len (nonzero), return to IDLE next edge with done=1 for one cycle.
REQ-026 SHALL, on stop=1 in RUN, enter IDLE at the next edge with drv0=drv1=edge0=0 and no done.
REQ-027 SHALL ignore start while in RUN.
REQ-028 SHALL hold drv0, drv1 at 0 and edge0, done at 0 throughout IDLE.
REQ-029 SHALL use counters of CNT_W bits; period counting never wraps because compare precedes overflow.

Reset
REQ-030 SHALL, when rst_n=0 at a clock edge, force state=IDLE, all outputs 0, counters 0, hp0=HP0_DEF, hp1=HP1_DEF, burst_len=0.
REQ-031 SHALL abort a run mid-operation on reset without asserting done.

Structure
REQ-032 SHALL place state enum and cfg_sel encodings in shared package stim_pkg.
REQ-033 SHALL instantiate one sub-module sq_div (counter + compare + toggle) twice, for drv0 and drv1.

Verification
REQ-034 Reset then start, defaults -> drv0 first rises 200 cycles after accept, drv1 at 400; edge0 coincident with each drv0 toggle.
REQ-035 cfg hp0=3, hp1=6, burst_len=2, start -> drv0 period 6, drv1 period 12; done pulses once after 2nd drv1 fall; busy drops same edge.
REQ-036 Running continuous, stop asserted at cycle 10 -> next edge busy=0, drv0=drv1=0, done stays 0.
REQ-037 In IDLE, start and stop same cycle -> stays IDLE; cfg_we during RUN with hp0=9 -> period unchanged.
REQ-038 cfg hp0=0 -> stored 1, drv0 toggles every cycle; rst_n=0 mid-run -> all outputs 0, hp0 back to 200.
